// File: rtl/fnd_pkg.sv
// Shared helpers for the FND display path: BCD encoding and prescaler sizing.
// Latency: n/a (elaboration-time functions only).
// Backpressure: n/a.
package fnd_pkg;

    localparam int BCD_W      = 4;
    localparam int MAX_DIGITS = 8;

    function automatic logic [BCD_W*MAX_DIGITS-1:0] to_bcd(input int value);
        logic [BCD_W*MAX_DIGITS-1:0] bcd;
        int v;
        v   = value;
        bcd = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            bcd[i*BCD_W +: BCD_W] = 4'(v % 10);
            v = v / 10;
        end
        return bcd;
    endfunction

    function automatic int calc_div(input int f_clk_hz, input int f_tick_hz);
        return f_clk_hz / f_tick_hz;
    endfunction

    function automatic longint pow10(input int n);
        longint p;
        p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

endpackage

// File: rtl/bcd_updown_counter_tick_gen.sv
// Prescaler: counts 0..DIV-1 while enabled, holds phase while paused.
// Latency: o_tick is combinational in the cycle the prescaler sits at DIV-1.
// Backpressure: none; i_en low simply freezes the phase.
module tick_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;
    logic          last;

    assign last   = (cnt == CW'(DIV - 1));
    assign o_tick = i_en && last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (i_clr) begin
            cnt <= '0;
        end else if (i_en) begin
            if (last) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/bcd_updown_counter.sv
// N-digit BCD up/down counter stepped by an internal prescaler tick.
// Latency: o_bcd/o_tick/o_wrap/o_load_err register 1 clk after the causing cycle.
// Backpressure: none; i_run low pauses both prescaler and counting.
module bcd_updown_counter
    import fnd_pkg::*;
#(
    parameter int F_CLK_HZ  = 100_000_000,
    parameter int F_TICK_HZ = 10,
    parameter int DIGITS    = 4,
    parameter int MAX_COUNT = 9999
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_run,
    input  logic                      i_clear,
    input  logic                      i_up,
    input  logic                      i_wrap_en,
    input  logic                      i_load,
    input  logic [BCD_W*DIGITS-1:0]   i_load_value,
    output logic [BCD_W*DIGITS-1:0]   o_bcd,
    output logic                      o_tick,
    output logic                      o_wrap,
    output logic                      o_load_err
);

    localparam int W   = BCD_W * DIGITS;
    localparam int DIV = calc_div(F_CLK_HZ, F_TICK_HZ);
    localparam logic [BCD_W*MAX_DIGITS-1:0] MAX_BCD_ALL = to_bcd(MAX_COUNT);
    localparam logic [W-1:0]                MAX_BCD     = MAX_BCD_ALL[W-1:0];

    if (F_CLK_HZ % F_TICK_HZ != 0) begin : g_err_div_frac
        $error("F_CLK_HZ must be an integer multiple of F_TICK_HZ");
    end
    if (DIV < 2) begin : g_err_div_small
        $error("F_CLK_HZ/F_TICK_HZ must be at least 2");
    end
    if (DIGITS < 1 || DIGITS > MAX_DIGITS) begin : g_err_digits
        $error("DIGITS must be in 1..8");
    end
    if (MAX_COUNT < 0 || longint'(MAX_COUNT) > pow10(DIGITS) - 1) begin : g_err_max
        $error("MAX_COUNT does not fit in DIGITS decimal digits");
    end

    logic              tick_evt;
    logic [W-1:0]      bcd_q;
    logic [W-1:0]      bcd_inc;
    logic [W-1:0]      bcd_dec;
    logic [W-1:0]      bcd_next;
    logic              step_wrap;
    logic [DIGITS-1:0] carry;
    logic [DIGITS-1:0] borrow;
    logic [DIGITS-1:0] ld_digit_ok;
    logic              load_ok;
    logic              at_max;
    logic              at_zero;
    logic              tick_q;
    logic              wrap_q;
    logic              err_q;

    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .i_en   (i_run),
        .i_clr  (i_clear),
        .o_tick (tick_evt)
    );

    assign carry[0]  = 1'b1;
    assign borrow[0] = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        logic [BCD_W-1:0] d;
        assign d = bcd_q[i*BCD_W +: BCD_W];

        assign bcd_inc[i*BCD_W +: BCD_W] = !carry[i]  ? d :
                                           (d == 4'd9) ? 4'd0 : d + 4'd1;
        assign bcd_dec[i*BCD_W +: BCD_W] = !borrow[i] ? d :
                                           (d == 4'd0) ? 4'd9 : d - 4'd1;
        assign ld_digit_ok[i] = (i_load_value[i*BCD_W +: BCD_W] <= 4'd9);

        if (i < DIGITS - 1) begin : g_chain
            assign carry[i+1]  = carry[i]  && (d == 4'd9);
            assign borrow[i+1] = borrow[i] && (d == 4'd0);
        end
    end

    // With every digit valid, BCD order matches numeric order, so a plain
    // unsigned compare against the BCD-encoded limit is exact.
    assign load_ok = (&ld_digit_ok) && (i_load_value <= MAX_BCD);
    assign at_max  = (bcd_q == MAX_BCD);
    assign at_zero = (bcd_q == '0);

    always_comb begin
        bcd_next  = bcd_q;
        step_wrap = 1'b0;
        if (i_up) begin
            if (at_max) begin
                if (i_wrap_en) begin
                    bcd_next  = '0;
                    step_wrap = 1'b1;
                end
            end else begin
                bcd_next = bcd_inc;
            end
        end else begin
            if (at_zero) begin
                if (i_wrap_en) begin
                    bcd_next  = MAX_BCD;
                    step_wrap = 1'b1;
                end
            end else begin
                bcd_next = bcd_dec;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcd_q  <= '0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else if (i_clear) begin
            bcd_q  <= '0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else if (i_load) begin
            if (load_ok) begin
                bcd_q <= i_load_value;
            end
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
            err_q  <= !load_ok;
        end else if (tick_evt) begin
            bcd_q  <= bcd_next;
            tick_q <= 1'b1;
            wrap_q <= step_wrap;
            err_q  <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end
    end

    assign o_bcd      = bcd_q;
    assign o_tick     = tick_q;
    assign o_wrap     = wrap_q;
    assign o_load_err = err_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench for bcd_updown_counter with DIV=10, two digits, limit 59.
module tb_bcd_updown_counter;

    logic       clk;
    logic       reset;
    logic       i_run;
    logic       i_clear;
    logic       i_up;
    logic       i_wrap_en;
    logic       i_load;
    logic [7:0] i_load_value;
    logic [7:0] o_bcd;
    logic       o_tick;
    logic       o_wrap;
    logic       o_load_err;

    int checks;
    int errors;

    bcd_updown_counter #(
        .F_CLK_HZ  (100),
        .F_TICK_HZ (10),
        .DIGITS    (2),
        .MAX_COUNT (59)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_run        (i_run),
        .i_clear      (i_clear),
        .i_up         (i_up),
        .i_wrap_en    (i_wrap_en),
        .i_load       (i_load),
        .i_load_value (i_load_value),
        .o_bcd        (o_bcd),
        .o_tick       (o_tick),
        .o_wrap       (o_wrap),
        .o_load_err   (o_load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // n cycles with no tick, then a tick carrying the given count and wrap flag.
    task automatic tick_after(input int n, input logic [7:0] exp_bcd, input logic exp_wrap,
                              input string tag);
        for (int i = 1; i < n; i++) begin
            step();
            check({tag, "_idle"}, 32'(o_tick), 32'd0);
        end
        step();
        check({tag, "_tick"}, 32'(o_tick), 32'd1);
        check({tag, "_bcd"}, 32'(o_bcd), 32'(exp_bcd));
        check({tag, "_wrap"}, 32'(o_wrap), 32'(exp_wrap));
    endtask

    task automatic do_load(input logic [7:0] value, input logic [7:0] exp_bcd,
                           input logic exp_err, input string tag);
        i_load       = 1'b1;
        i_load_value = value;
        step();
        i_load = 1'b0;
        check({tag, "_bcd"}, 32'(o_bcd), 32'(exp_bcd));
        check({tag, "_err"}, 32'(o_load_err), 32'(exp_err));
        check({tag, "_tick"}, 32'(o_tick), 32'd0);
        step();
        check({tag, "_err_clr"}, 32'(o_load_err), 32'd0);
    endtask

    initial begin
        int         k;
        logic [7:0] exp_bcd;
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        i_run        = 1'b0;
        i_clear      = 1'b0;
        i_up         = 1'b1;
        i_wrap_en    = 1'b1;
        i_load       = 1'b0;
        i_load_value = 8'h00;
        step();
        step();
        reset = 1'b0;
        check("rst_bcd", 32'(o_bcd), 32'h00);
        check("rst_tick", 32'(o_tick), 32'd0);
        check("rst_wrap", 32'(o_wrap), 32'd0);
        check("rst_err", 32'(o_load_err), 32'd0);

        // Full wrap-around sweep 00..59..00
        i_run = 1'b1;
        for (int n = 1; n <= 600; n++) begin
            step();
            k       = (n / 10) % 60;
            exp_bcd = 8'(((k / 10) << 4) | (k % 10));
            check("sweep_tick", 32'(o_tick), 32'((n % 10) == 0));
            check("sweep_bcd", 32'(o_bcd), 32'(exp_bcd));
            check("sweep_wrap", 32'(o_wrap), 32'(n == 600));
        end
        i_run = 1'b0;

        // Saturate at the top
        do_load(8'h58, 8'h58, 1'b0, "ld58");
        i_run     = 1'b1;
        i_wrap_en = 1'b0;
        tick_after(10, 8'h59, 1'b0, "sat1");
        tick_after(10, 8'h59, 1'b0, "sat2");
        tick_after(10, 8'h59, 1'b0, "sat3");
        i_run = 1'b0;

        // Down through zero with wrap, then saturate at zero
        do_load(8'h01, 8'h01, 1'b0, "ld01");
        i_run     = 1'b1;
        i_up      = 1'b0;
        i_wrap_en = 1'b1;
        tick_after(10, 8'h00, 1'b0, "dn00");
        tick_after(10, 8'h59, 1'b1, "dnwrap");
        tick_after(10, 8'h58, 1'b0, "dn58");
        i_run = 1'b0;
        do_load(8'h00, 8'h00, 1'b0, "ld00");
        i_run     = 1'b1;
        i_wrap_en = 1'b0;
        tick_after(10, 8'h00, 1'b0, "dnsat1");
        tick_after(10, 8'h00, 1'b0, "dnsat2");
        i_run = 1'b0;

        // Rejected and accepted loads
        do_load(8'h5A, 8'h00, 1'b1, "ld5a");
        do_load(8'h60, 8'h00, 1'b1, "ld60");
        do_load(8'h42, 8'h42, 1'b0, "ld42");

        // Pause at prescaler phase 4 for 37 clocks
        i_up      = 1'b1;
        i_wrap_en = 1'b1;
        i_run     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("pre_pause_tick", 32'(o_tick), 32'd0);
        end
        i_run = 1'b0;
        for (int i = 0; i < 37; i++) begin
            step();
            check("pause_tick", 32'(o_tick), 32'd0);
            check("pause_bcd", 32'(o_bcd), 32'h42);
        end
        i_run = 1'b1;
        tick_after(6, 8'h43, 1'b0, "resume");

        // Clear in the tick cycle
        for (int i = 0; i < 9; i++) begin
            step();
            check("pre_clr_tick", 32'(o_tick), 32'd0);
        end
        i_clear = 1'b1;
        step();
        i_clear = 1'b0;
        check("clr_bcd", 32'(o_bcd), 32'h00);
        check("clr_tick", 32'(o_tick), 32'd0);
        check("clr_wrap", 32'(o_wrap), 32'd0);
        tick_after(10, 8'h01, 1'b0, "post_clr");

        // Asynchronous reset while o_tick is high
        #2 reset = 1'b1;
        #1;
        check("arst_bcd", 32'(o_bcd), 32'h00);
        check("arst_tick", 32'(o_tick), 32'd0);
        step();
        reset = 1'b0;
        check("arst_hold_bcd", 32'(o_bcd), 32'h00);
        tick_after(10, 8'h01, 1'b0, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_updown_counter.md
Name: bcd_updown_counter

Overview:
- Parametrised N-digit BCD counter with an integrated tick prescaler.
- Steps once per tick: up or down, wrap or saturate, with run, clear and load control.
- Everything runs on the single system clock; the tick is a one-cycle enable, never a derived clock.
- Feeds the FND display controller directly with packed BCD digits.

Parameters:
- F_CLK_HZ, 100_000_000, system clock frequency.
- F_TICK_HZ, 10, count rate. DIV = F_CLK_HZ/F_TICK_HZ must be an integer ≥2 (elaboration error otherwise).
- DIGITS, 4, number of BCD digits (1..8).
- MAX_COUNT, 9999, terminal value in decimal. Must be ≤10^DIGITS−1 (elaboration error otherwise).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_run  in  1  1 = prescaler advances and counting enabled; 0 = pause.
- i_clear  in  1  synchronous clear of count and prescaler.
- i_up  in  1  1 = count up, 0 = count down; sampled at each tick.
- i_wrap_en  in  1  1 = wrap at the boundaries, 0 = saturate.
- i_load  in  1  synchronous load strobe.
- i_load_value  in  4*DIGITS  packed BCD load value; digit 0 is in [3:0].
- o_bcd  out  4*DIGITS  packed BCD count; digit 0 is in [3:0].
- o_tick  out  1  one-cycle pulse, high in the cycle the new count is first visible.
- o_wrap  out  1  one-cycle pulse coincident with o_tick when a wrap occurred.
- o_load_err  out  1  one-cycle pulse when a load was rejected.

Behaviour:
- Reset: prescaler=0, o_bcd=0, o_tick=0, o_wrap=0, o_load_err=0. Asynchronous assert; deassert takes effect on the next clk edge.
- Prescaler: counts 0..DIV−1 while i_run=1 and holds its value while i_run=0, so a pause resumes the same tick phase.
  - A tick event occurs in the cycle the prescaler equals DIV−1 with i_run=1; the prescaler returns to 0 on that edge.
- Priority per cycle: i_clear > i_load > tick step.
- i_clear:
  - Next edge: o_bcd=0, prescaler=0.
  - o_tick, o_wrap and o_load_err are 0 in the following cycle, even if a tick or load coincided.
  - Effective regardless of i_run.
- i_load:
  - Accepted only if every digit is ≤9 and the value is ≤MAX_COUNT. Then o_bcd takes the value on the next edge.
  - Otherwise o_bcd is unchanged and o_load_err pulses for 1 cycle.
  - Prescaler untouched; a coincident tick is discarded (no step, o_tick=0).
  - Effective regardless of i_run.
- Tick step, registered: o_bcd updates on the edge ending the tick cycle, and o_tick=1 for exactly that following cycle. Latency is 1 clk.
  - Up: digit ripple 9→0 with carry to the next digit.
  - Up at MAX_COUNT: wrap_en=1 → 0 with o_wrap=1; wrap_en=0 → hold at MAX_COUNT, o_wrap=0, o_tick still pulses.
  - Down: digit ripple 0→9 with borrow.
  - Down at 0: wrap_en=1 → MAX_COUNT with o_wrap=1; wrap_en=0 → hold at 0.
  - Direction change takes effect at the next tick with no extra latency.
- o_bcd never holds an invalid BCD digit or a value >MAX_COUNT.
- Comparisons against MAX_COUNT use its BCD encoding, computed at elaboration.
- Reset mid-count: all state is lost immediately and counting resumes from 0 with a full DIV period after release.

Decomposition:
- Shared package (fnd_pkg):
  - function to_bcd(int) → packed BCD, used for the MAX_COUNT constant;
  - function calc_div(F_CLK_HZ, F_TICK_HZ);
  - localparam BCD_W = 4.
- Sub-module tick_gen (parameter DIV; ports clk, reset, i_en, i_clr, o_tick) holds the prescaler.
- The BCD digit chain is a generate loop in the top module; no per-digit sub-module.

Test Plan (F_CLK_HZ=100, F_TICK_HZ=10 → DIV=10, DIGITS=2, MAX_COUNT=59):
1. Reset, then run=1, up=1, wrap_en=1 for 600 clks → o_tick every 10 clks; o_bcd goes 00,01,…,59,00; o_wrap pulses once, with 59→00.
2. Load 0x58 then run up with wrap_en=0 → 58, 59, 59, 59; o_tick keeps pulsing; o_wrap never asserts.
3. Load 0x01 then run down with wrap_en=1 → 01, 00, 59 with o_wrap; then 58. With wrap_en=0 the count holds at 00.
4. Load 0x5A (invalid digit) and 0x60 (>59) → o_bcd unchanged; o_load_err pulses 1 cycle for each; a following load of 0x42 gives o_bcd=0x42.
5. Pause: run=0 at prescaler=4 for 37 clks, then run=1 → the next o_tick arrives exactly 6 clks after resume; o_bcd is frozen during the pause.
6. Clear asserted in the same cycle as a tick, and reset asserted mid-period → o_bcd=00, o_tick=0, and the next tick comes 10 clks later. Async reset zeroes the outputs without waiting for a clk edge.
